// File: rtl/pong_match_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module : pong_match_sequencer                                              |
// | Match-level serve/rally/point/game-over controller for the Pong datapath.  |
// | Optional: PONG_SEQ_PAUSE_EN adds i_pause and the pause toggle.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pong_match_sequencer #(
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_HOLD_FRAMES  = 90,
  parameter int WIN_SCORE          = 7
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_start,
  input  logic       i_frame_tick,
  input  logic       i_ball_out_left,
  input  logic       i_ball_out_right,
`ifdef PONG_SEQ_PAUSE_EN
  input  logic       i_pause,
`endif
  output logic       o_serve,
  output logic       o_serve_dir,
  output logic       o_run,
  output logic [3:0] o_left_score,
  output logic [3:0] o_right_score,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [2:0] o_state
);

  localparam int             CNT_W      = 10;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_HOLD_FRAMES - 1);
  localparam logic [3:0]     WIN        = 4'(WIN_SCORE);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SERVE_WAIT = 3'd1;
  localparam logic [2:0] S_RALLY      = 3'd2;
  localparam logic [2:0] S_POINT      = 3'd3;
  localparam logic [2:0] S_GAME_OVER  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       left_q, left_d;
  logic [3:0]       right_q, right_d;
  logic             dir_q, dir_d;
  logic             serve_q, serve_d;
  logic             run_q, run_d;
  logic             over_q, over_d;
  logic             winner_q, winner_d;
  logic             start_q;
  logic             pause_q, pause_d;
  logic             w_start_evt;
  logic             w_paused;

  assign w_start_evt = i_start & ~start_q;

`ifdef PONG_SEQ_PAUSE_EN
  logic pause_in_q;
  logic w_pause_evt;

  assign w_pause_evt = i_pause & ~pause_in_q;
  assign w_paused    = pause_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) pause_in_q <= 1'b0;
    else          pause_in_q <= i_pause;
  end
`else
  assign w_paused = 1'b0;
`endif

  // State register plus all registered outputs and counters
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      left_q   <= 4'd0;
      right_q  <= 4'd0;
      dir_q    <= 1'b1;
      serve_q  <= 1'b0;
      run_q    <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      dir_q    <= dir_d;
      serve_q  <= serve_d;
      run_q    <= run_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      start_q  <= i_start;
      pause_q  <= pause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    right_d  = right_q;
    dir_d    = dir_q;
    serve_d  = 1'b0;
    over_d   = over_q;
    winner_d = winner_q;
    pause_d  = pause_q;

    case (state_q)
      S_IDLE: begin
        if (w_start_evt) begin
          state_d = S_SERVE_WAIT;
          cnt_d   = '0;
          left_d  = 4'd0;
          right_d = 4'd0;
          dir_d   = 1'b1;
        end
      end
      S_SERVE_WAIT: begin
        if (!w_paused && i_frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = S_RALLY;
            serve_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RALLY: begin
        // Simultaneous outs are a no-score point; direction is kept
        if (!w_paused && (i_ball_out_left || i_ball_out_right)) begin
          state_d = S_POINT;
          cnt_d   = '0;
          if (i_ball_out_left && !i_ball_out_right) begin
            right_d = right_q + 4'd1;
            dir_d   = 1'b0;
          end else if (i_ball_out_right && !i_ball_out_left) begin
            left_d = left_q + 4'd1;
            dir_d  = 1'b1;
          end
        end
      end
      S_POINT: begin
        if (!w_paused && i_frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (left_q == WIN || right_q == WIN) begin
              state_d  = S_GAME_OVER;
              over_d   = 1'b1;
              winner_d = (right_q == WIN);
            end else begin
              state_d = S_SERVE_WAIT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GAME_OVER: begin
        if (w_start_evt) begin
          state_d = S_SERVE_WAIT;
          cnt_d   = '0;
          left_d  = 4'd0;
          right_d = 4'd0;
          dir_d   = 1'b1;
          over_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        over_d  = 1'b0;
      end
    endcase

`ifdef PONG_SEQ_PAUSE_EN
    if (w_pause_evt &&
        (state_q == S_SERVE_WAIT || state_q == S_RALLY || state_q == S_POINT))
      pause_d = ~pause_q;
`endif
    if (state_d == S_IDLE || state_d == S_GAME_OVER)
      pause_d = 1'b0;

    run_d = (state_d == S_RALLY) && !pause_d;
  end

  always_comb begin
    o_serve       = serve_q;
    o_serve_dir   = dir_q;
    o_run         = run_q;
    o_left_score  = left_q;
    o_right_score = right_q;
    o_game_over   = over_q;
    o_winner      = winner_q;
    o_state       = state_q;
  end

endmodule

`default_nettype wire

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
Match-level controller for the Pong datapath: sequences serves, enables and halts ball motion, keeps both players' scores, and declares the winner. Sits between the player buttons, the ball-motion engine and the pixel renderer. Consumes per-frame ticks and ball-out events from the ball engine. Drives serve commands, a run enable and score/state outputs to the ball engine and the score overlay.

Parameters:
SERVE_DELAY_FRAMES, 60, frame ticks spent in SERVE_WAIT before a serve is issued (1..1023)
POINT_HOLD_FRAMES, 90, frame ticks spent in POINT before the next decision (1..1023)
WIN_SCORE, 7, score that ends the match (1..15)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_start  in  1  start button, level, synchronous to i_Clk
i_frame_tick  in  1  one-cycle pulse per video frame
i_ball_out_left  in  1  one-cycle pulse: ball passed left paddle (right player scores)
i_ball_out_right  in  1  one-cycle pulse: ball passed right paddle (left player scores)
i_pause  in  1  pause level; port exists only with PONG_SEQ_PAUSE_EN
o_serve  out  1  one-cycle pulse: ball engine recentres and launches the ball
o_serve_dir  out  1  launch direction, 1 = toward right, 0 = toward left; valid whenever o_serve=1
o_run  out  1  ball motion enable
o_left_score  out  4  left player score
o_right_score  out  4  right player score
o_game_over  out  1  high in GAME_OVER
o_winner  out  1  0 = left won, 1 = right won; valid while o_game_over=1
o_state  out  3  current state encoding

Behaviour:
- Reset (async assert, sync release): state IDLE, scores 0, o_serve 0, o_serve_dir 1, o_run 0, o_game_over 0, o_winner 0, counters 0, start edge register 0.
- Start event = rising edge of i_start (previous-sample register); level held high never re-triggers.
- States / o_state: IDLE=0, SERVE_WAIT=1, RALLY=2, POINT=3, GAME_OVER=4.
- IDLE: start event -> SERVE_WAIT next cycle; scores cleared, o_serve_dir=1.
- SERVE_WAIT: frame counter increments per i_frame_tick; on the tick where count == SERVE_DELAY_FRAMES-1 -> next cycle state RALLY, o_serve=1 for exactly that one cycle, counter cleared.
- RALLY: o_run=1 (registered, high from first RALLY cycle). i_ball_out_left -> right_score+1; i_ball_out_right -> left_score+1; state POINT and new score visible in the same next cycle; o_run=0 from that cycle.
- Both out pulses in the same cycle: no score change, state POINT, o_serve_dir unchanged.
- Serve direction after a point: toward the player who conceded (out_left -> dir 0, out_right -> dir 1).
- POINT: counts POINT_HOLD_FRAMES ticks same as SERVE_WAIT; at expiry, if either score == WIN_SCORE -> GAME_OVER, o_game_over=1, o_winner set; else -> SERVE_WAIT.
- GAME_OVER: scores frozen, o_run=0; start event -> scores cleared, o_game_over=0, o_serve_dir=1, SERVE_WAIT.
- Ball-out pulses outside RALLY ignored. Start events outside IDLE/GAME_OVER ignored.
- Scores never exceed WIN_SCORE (match ends on reaching it); 4-bit unsigned.
- Tick and state change in same cycle: tick counted only if state was already SERVE_WAIT/POINT before the edge; counters zeroed on state entry.
- Reset mid-match: immediate return to reset values regardless of clock.
- Illegal o_state encodings (5-7) -> IDLE next cycle.

Optional Feature:
PONG_SEQ_PAUSE_EN: adds i_pause. Pause toggles on each rising edge of i_pause while in SERVE_WAIT, RALLY or POINT; while paused o_run=0, frame counters hold, ball-out pulses ignored, o_state unchanged; unpause resumes exactly where it stopped. Pause flag cleared on entry to IDLE/GAME_OVER and by reset. Without macro: no i_pause port, no pause logic, behaviour otherwise identical.

Test Plan:
Params SERVE_DELAY_FRAMES=2, POINT_HOLD_FRAMES=3, WIN_SCORE=3. Reset, pulse i_start, 2 ticks -> o_serve one cycle with o_serve_dir=1, o_state=2, o_run=1.
In RALLY pulse i_ball_out_left -> next cycle o_right_score=1, o_state=3, o_run=0; after 3 ticks SERVE_WAIT, next serve o_serve_dir=0.
Same-cycle out_left and out_right -> scores unchanged, POINT, then serve with previous direction.
Left scores 3 points -> after 3rd POINT hold o_game_over=1, o_winner=0, o_left_score=3; extra out pulses and ticks change nothing; start edge -> scores 0, o_state=1.
Hold i_start high through GAME_OVER entry -> no restart until release and re-press; assert i_Rst_n=0 mid-RALLY -> outputs at reset values without clock edge.
With PONG_SEQ_PAUSE_EN: pause after 1 tick in SERVE_WAIT, feed 5 ticks -> no serve; unpause, 1 tick -> o_serve.
